// File: rtl/ysyx_25040101_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
// Owner encoding doubles as the round-robin "last grant" value.
package ysyx_25040101_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/ysyx_25040101_rr_arb2.sv
// 2-way round-robin picker: grant bit 0 = IFU, bit 1 = LSU.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its own state.
module ysyx_25040101_rr_arb2
    import ysyx_25040101_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = req_i;
        // On a tie the requester that did not win last time goes first.
        if (req_i == 2'b11) begin
            grant_o = (last_i == OWN_LSU) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ysyx_25040101_mem_arbiter.sv
// Serializes IFU and LSU requests onto one memory port (IDLE/REQ/RESP FSM).
// Latency: 3 cycles request-to-response with a ready memory and 1-cycle reply.
// Backpressure: req_ready only in IDLE for the winner; REQ waits on mem_req_ready forever.
module ysyx_25040101_mem_arbiter
    import ysyx_25040101_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e           state_q;
    logic             owner_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]        grant;
    logic              idle_ok;
    logic              ifu_hs;
    logic              lsu_hs;
    logic              rsp_hit;
    logic              rsp_tmo;
    logic [DATA_W-1:0] rsp_data_d;

    ysyx_25040101_rr_arb2 u_rr_arb2 (
        .req_i   ({lsu_req_valid, ifu_req_valid}),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // Ready is forced low while reset is held so it matches the reset values.
    assign idle_ok       = rst && (state_q == IDLE);
    assign ifu_req_ready = idle_ok && grant[0];
    assign lsu_req_ready = idle_ok && grant[1];
    assign ifu_hs        = ifu_req_valid && ifu_req_ready;
    assign lsu_hs        = lsu_req_valid && lsu_req_ready;

    // A real response in the timeout cycle takes priority over the error.
    assign rsp_hit    = (state_q == RESP) && mem_rsp_valid;
    assign rsp_tmo    = (state_q == RESP) && !mem_rsp_valid && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign rsp_data_d = (rsp_tmo || mem_wen) ? '0 : mem_rsp_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_IFU;
            last_q        <= OWN_LSU;
            cnt_q         <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_data  <= '0;
            ifu_rsp_err   <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
            lsu_rsp_err   <= 1'b0;
        end else begin
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_err   <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_err   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ifu_hs) begin
                        owner_q       <= OWN_IFU;
                        last_q        <= OWN_IFU;
                        mem_req_valid <= 1'b1;
                        mem_addr      <= ifu_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_wmask     <= '1;
                        state_q       <= REQ;
                    end else if (lsu_hs) begin
                        owner_q       <= OWN_LSU;
                        last_q        <= OWN_LSU;
                        mem_req_valid <= 1'b1;
                        mem_addr      <= lsu_addr;
                        mem_wen       <= lsu_wen;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wmask;
                        state_q       <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (rsp_hit || rsp_tmo) begin
                        if (owner_q == OWN_IFU) begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rsp_data  <= rsp_data_d;
                            ifu_rsp_err   <= rsp_tmo;
                        end else begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_data  <= rsp_data_d;
                            lsu_rsp_err   <= rsp_tmo;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_25040101_mem_arbiter.md
# ysyx_25040101_mem_arbiter

Two-requester memory arbiter and transaction sequencer for the core's shared memory port. It serializes instruction-fetch (IFU) and load/store (LSU) requests onto one memory interface with a three-state FSM, round-robin grant and a response timeout. It sits between the fetch/LSU front ends and the single memory slave, so the core can move from single-cycle combinational memory to a multi-cycle bus.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; mask width is DATA_W/8
- TIMEOUT, 255, cycles in RESP before an error response is forced; minimum 1
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_addr  input  ADDR_W  fetch address
- ifu_rsp_valid  output  1  one-cycle response pulse
- ifu_rsp_data  output  DATA_W  fetched word
- ifu_rsp_err  output  1  timeout flag, qualified by ifu_rsp_valid
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  input  ADDR_W  load/store address
- lsu_wen  input  1  1 = store
- lsu_wdata  input  DATA_W  store data
- lsu_wmask  input  DATA_W/8  byte enables
- lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err  output  1 / DATA_W / 1  same meaning as the IFU response outputs
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  output  widths as on the LSU side  registered request fields
- mem_rsp_valid  input  1  memory response strobe
- mem_rsp_data  input  DATA_W  read data; ignored for stores

## Operation
- FSM states: IDLE, REQ, RESP. Reset state is IDLE.
- IDLE, grant selection (combinational):
  - If only one requester is valid, it wins.
  - If both are valid, the one not granted last wins.
  - The last-grant register resets to LSU, so IFU wins the first tie.
- Only the winner sees req_ready=1, and only in IDLE. The loser's ready is 0.
- On the winner's handshake:
  - Latch addr, wen, wdata and wmask into the mem_* registers, plus the owner bit.
  - For IFU: wen=0, wmask all ones, wdata 0.
  - Move to REQ.
- REQ: mem_req_valid=1 with stable fields. When mem_req_ready=1, clear the timeout counter and move to RESP.
- RESP: wait for mem_rsp_valid.
  - On response: pulse the owner's rsp_valid for 1 cycle with rsp_data=mem_rsp_data (0 for stores) and rsp_err=0. Go to IDLE.
  - The timeout counter increments each RESP cycle. When it reaches TIMEOUT with no response, pulse the owner's rsp_valid with data 0 and rsp_err=1, then go to IDLE.
- mem_rsp_valid in IDLE or REQ is dropped; no response is generated.
- Requesters always accept responses; there is no response back-pressure.
- A transaction in REQ is never abandoned: the arbiter waits on mem_req_ready indefinitely.

## Timing
- Reset values:
  - all *_req_ready, *_rsp_valid and *_rsp_err = 0
  - rsp_data = 0
  - mem_req_valid = 0, mem_addr/wdata/wmask = 0, mem_wen = 0
  - counter = 0, last-grant = LSU
- Reset asserted mid-transaction returns to IDLE immediately and asynchronously. No response is emitted for the aborted transaction.
- Minimum latency, with memory ready and a 1-cycle response:
  - cycle 0: request handshake
  - cycle 1: mem_req_valid, handshake
  - cycle 2: mem_rsp_valid
  - cycle 3: rsp_valid (registered output)
  - Next grant can occur at cycle 4.
- Response outputs are registered; mem_* request outputs are registered; req_ready is combinational from FSM state and the valid inputs.
- Timeout fires on the TIMEOUT-th RESP cycle after the mem handshake. If mem_rsp_valid arrives in that same cycle, the real response wins.
- A new request arriving while the arbiter is busy is held by its requester (valid stays high). Arbitration happens on return to IDLE.

## Structure
- Shared package ysyx_25040101_pkg holds:
  - the state enum (IDLE=2'd0, REQ=2'd1, RESP=2'd2)
  - the owner encoding (OWN_IFU=1'b0, OWN_LSU=1'b1)
  - default width constants
- One sub-module: ysyx_25040101_rr_arb2, a 2-way round-robin picker (req[1:0], last, grant one-hot).
- The FSM, request registers and timeout counter live in the top module.

## Test plan
- IFU only: addr 0x80000000, memory ready, returns 0x00100073 after 1 cycle -> ifu_rsp_valid at cycle 3 with data 0x00100073 and err=0; lsu_rsp_valid stays 0.
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011 -> mem_* fields match, mem_wen=1; lsu_rsp_valid with data 0.
- Both valid every cycle for 6 grants -> order IFU, LSU, IFU, LSU, IFU, LSU; no starvation.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid and fields stable throughout; exactly one handshake.
- TIMEOUT=4, no response -> owner rsp_valid with err=1 and data 0 on RESP cycle 4. A late mem_rsp_valid in IDLE is ignored.
- rst dropped in RESP -> all outputs at reset values at once. After release, an IFU request proceeds normally with IFU winning the first tie.
